rom_load_ctrl: RTL and testbench

- Sequences the HPS ROM download (ioctl stream) into the Canyon Bomber core's ROM regions.
- Decodes each download byte into a one-hot region write strobe with a region-local address.
- Owns the core's active-low run reset: holds the core in reset during and after a download, validates the byte count, then releases.
- Sits between hps_io and canyon_bomber in the top level and replaces the direct ioctl wiring and the ORed reset term.

---
 rtl/canyon_rom_pkg.sv | 20 ++
 rtl/rom_region_decode.sv | 39 +++
 rtl/rom_load_ctrl.sv | 159 +++++++++++++++
 tb/tb_rom_load_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/canyon_rom_pkg.sv
// Memory map and FSM state type shared by the Canyon Bomber ROM loader
// and its address decoder.
package canyon_rom_pkg;

  localparam int ROM_REGIONS = 4;

  localparam logic [24:0] REGION_BASE [ROM_REGIONS] = '{25'h0000, 25'h0800, 25'h1000, 25'h1200};
  localparam logic [24:0] REGION_SIZE [ROM_REGIONS] = '{25'h0800, 25'h0800, 25'h0200, 25'h0200};
  localparam logic [24:0] TOTAL_BYTES = 25'h1400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_HOLD,
    ST_RUN,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational decode of a download byte address into a one-hot ROM
// region hit plus the offset inside that region.
module rom_region_decode
  import canyon_rom_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int LOC_W       = 11
) (
  input  logic [24:0]            dl_addr,
  output logic [NUM_REGIONS-1:0] hit,
  output logic [LOC_W-1:0]       offset,
  output logic                   out_of_range
);

  logic [NUM_REGIONS-1:0] match;
  logic [24:0]            rel [NUM_REGIONS];

  // An address below the base wraps to a huge value, so one compare suffices.
  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
    assign rel[gi]   = dl_addr - REGION_BASE[gi];
    assign match[gi] = (rel[gi] < REGION_SIZE[gi]);
  end

  // Descending scan so the lowest-numbered matching region wins.
  always_comb begin
    hit    = '0;
    offset = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit    = '0;
        hit[k] = 1'b1;
        offset = rel[k][LOC_W-1:0];
      end
    end
  end

  assign out_of_range = (dl_addr >= TOTAL_BYTES);

endmodule

// File: rtl/rom_load_ctrl.sv
// Steers the HPS ioctl ROM download into the core's ROM regions and owns
// the core's run reset: held low while loading, released after a valid load.
module rom_load_ctrl
  import canyon_rom_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int LOC_W       = 11,
  parameter int RST_HOLD    = 16
) (
  input  logic                   clk_sys,
  input  logic                   Reset_I,
  input  logic                   dl_active,
  input  logic                   dl_wr,
  input  logic [24:0]            dl_addr,
  input  logic [7:0]             dl_data,
  input  logic                   soft_rst,
  output logic [NUM_REGIONS-1:0] wr_en,
  output logic [LOC_W-1:0]       wr_addr,
  output logic [7:0]             wr_data,
  output logic                   core_rst_n,
  output logic                   busy,
  output logic                   err_size,
  output logic                   err_range,
  output logic [15:0]            byte_count
);

  localparam int              HOLD_W      = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [15:0]     TOTAL_CNT   = 16'(TOTAL_BYTES);

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   dl_active_q;
  logic [NUM_REGIONS-1:0] wr_en_q, wr_en_d;
  logic [LOC_W-1:0]       wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   err_size_q, err_size_d;
  logic                   err_range_q, err_range_d;
  logic [15:0]            byte_count_q, byte_count_d;

  logic                   dl_rise, dl_fall, accept, count_bad;
  logic [NUM_REGIONS-1:0] dec_hit;
  logic [LOC_W-1:0]       dec_offset;
  logic                   dec_oor;

  rom_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .LOC_W       (LOC_W)
  ) u_decode (
    .dl_addr      (dl_addr),
    .hit          (dec_hit),
    .offset       (dec_offset),
    .out_of_range (dec_oor)
  );

  // The edge detector resets high so a download already in flight when
  // reset lifts is not mistaken for a fresh one.
  assign dl_rise   = dl_active & ~dl_active_q;
  assign dl_fall   = ~dl_active & dl_active_q;
  assign accept    = dl_active & dl_wr & (state_q == ST_LOAD);
  assign count_bad = (byte_count_q != TOTAL_CNT);

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      dl_active_q  <= 1'b1;
      wr_en_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      core_rst_n_q <= 1'b0;
      err_size_q   <= 1'b0;
      err_range_q  <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      dl_active_q  <= dl_active;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_rst_n_q <= core_rst_n_d;
      err_size_q   <= err_size_d;
      err_range_q  <= err_range_d;
      byte_count_q <= byte_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (dl_rise) begin
      state_d = ST_LOAD;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_LOAD: if (dl_fall) state_d = ST_CHECK;
        ST_CHECK: begin
          if (count_bad || err_range_q) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_HOLD;
            hold_d  = HOLD_RELOAD;
          end
        end
        ST_HOLD: begin
          if (soft_rst)            hold_d  = HOLD_RELOAD;
          else if (hold_q == '0)   state_d = ST_RUN;
          else                     hold_d  = hold_q - 1'b1;
        end
        ST_RUN: begin
          if (soft_rst) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_RELOAD;
          end
        end
        ST_FAIL: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en_d      = '0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    err_size_d   = err_size_q;
    err_range_d  = err_range_q;
    byte_count_d = byte_count_q;
    if (dl_rise) begin
      err_size_d   = 1'b0;
      err_range_d  = 1'b0;
      byte_count_d = '0;
    end else if (accept) begin
      if (dec_oor) begin
        err_range_d = 1'b1;
      end else begin
        wr_en_d   = dec_hit;
        wr_addr_d = dec_offset;
        wr_data_d = dl_data;
        if (byte_count_q != 16'hFFFF) byte_count_d = byte_count_q + 16'd1;
      end
    end
    if (!dl_rise && state_q == ST_CHECK && count_bad) err_size_d = 1'b1;
    core_rst_n_d = (state_d == ST_RUN);
    busy = (state_q == ST_LOAD) || (state_q == ST_CHECK) || (state_q == ST_HOLD);
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_rst_n = core_rst_n_q;
  assign err_size   = err_size_q;
  assign err_range  = err_range_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl: full, short and out-of-range loads,
// soft reset, reload from RUN and asynchronous reset during a download.
module tb_rom_load_ctrl;

  logic        clk_sys = 1'b0;
  logic        Reset_I;
  logic        dl_active, dl_wr, soft_rst;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [3:0]  wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_rst_n, busy, err_size, err_range;
  logic [15:0] byte_count;

  logic [24:0] dec_addr;
  logic [3:0]  dec_hit;
  logic [10:0] dec_offset;
  logic        dec_oor;

  int n_checks = 0;
  int n_fail   = 0;

  int dec_a   [6] = '{'h07FF, 'h0800, 'h11FF, 'h1200, 'h13FF, 'h1400};
  int dec_hit_x [6] = '{'h1, 'h2, 'h4, 'h8, 'h8, 'h0};
  int dec_off_x [6] = '{'h7FF, 'h000, 'h1FF, 'h000, 'h1FF, 'h000};
  int dec_oor_x [6] = '{0, 0, 0, 0, 0, 1};

  always #5 clk_sys = ~clk_sys;

  rom_load_ctrl #(
    .NUM_REGIONS (4),
    .LOC_W       (11),
    .RST_HOLD    (16)
  ) dut (
    .clk_sys    (clk_sys),
    .Reset_I    (Reset_I),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .soft_rst   (soft_rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .err_size   (err_size),
    .err_range  (err_range),
    .byte_count (byte_count)
  );

  rom_region_decode #(
    .NUM_REGIONS (4),
    .LOC_W       (11)
  ) u_ref_decode (
    .dl_addr      (dec_addr),
    .hit          (dec_hit),
    .offset       (dec_offset),
    .out_of_range (dec_oor)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] pat(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [3:0] exp_en(input int a);
    if (a < 'h0800) return 4'b0001;
    if (a < 'h1000) return 4'b0010;
    if (a < 'h1200) return 4'b0100;
    if (a < 'h1400) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic int exp_off(input int a);
    if (a < 'h0800) return a;
    if (a < 'h1000) return a - 'h0800;
    if (a < 'h1200) return a - 'h1000;
    return a - 'h1200;
  endfunction

  // Back-to-back byte writes; leaves dl_wr high after the last one.
  task automatic load_range(input int first, input int last, input bit check_each);
    for (int a = first; a <= last; a++) begin
      dl_addr = 25'(a);
      dl_data = pat(a);
      dl_wr   = 1'b1;
      tick();
      if (check_each) begin
        chk_eq("wr_en", wr_en, exp_en(a));
        if (a < 'h1400) begin
          chk_eq("wr_addr", wr_addr, exp_off(a));
          chk_eq("wr_data", wr_data, pat(a));
        end else begin
          chk_eq("oor_err_range", err_range, 1);
        end
        if (a == 'h1000) begin
          chk_eq("dir_1000_en", wr_en, 4'b0100);
          chk_eq("dir_1000_addr", wr_addr, 0);
        end
      end
    end
  endtask

  task automatic wait_core_up(input int exp_ticks, input string tag);
    int n;
    n = 0;
    while (core_rst_n !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk_eq(tag, n, exp_ticks);
  endtask

  task automatic end_download();
    dl_wr     = 1'b0;
    dl_active = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk_eq({tag, "_wr_en"}, wr_en, 0);
    chk_eq({tag, "_wr_addr"}, wr_addr, 0);
    chk_eq({tag, "_wr_data"}, wr_data, 0);
    chk_eq({tag, "_core_rst_n"}, core_rst_n, 0);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_err_size"}, err_size, 0);
    chk_eq({tag, "_err_range"}, err_range, 0);
    chk_eq({tag, "_byte_count"}, byte_count, 0);
  endtask

  initial begin
    Reset_I = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; soft_rst = 1'b0;
    dl_addr = '0; dl_data = '0; dec_addr = '0;
    repeat (3) tick();
    check_reset_vals("rst");
    Reset_I = 1'b1;
    repeat (3) tick();
    chk_eq("idle_busy", busy, 0);
    chk_eq("idle_core_rst_n", core_rst_n, 0);
    dl_wr = 1'b1; dl_addr = 25'h10; soft_rst = 1'b1;
    tick();
    chk_eq("idle_wr_ignored", wr_en, 0);
    dl_wr = 1'b0; soft_rst = 1'b0;
    tick();
    chk_eq("idle_soft_ignored", busy, 0);
    $display("reset and idle checked");

    for (int i = 0; i < 6; i++) begin
      dec_addr = 25'(dec_a[i]);
      #1;
      chk_eq("dec_hit", dec_hit, dec_hit_x[i]);
      chk_eq("dec_offset", dec_offset, dec_off_x[i]);
      chk_eq("dec_oor", dec_oor, dec_oor_x[i]);
    end
    $display("decoder boundaries checked");

    dl_active = 1'b1;
    tick();
    chk_eq("full_busy", busy, 1);
    chk_eq("full_count0", byte_count, 0);
    load_range(0, 'h13FF, 1'b1);
    end_download();
    chk_eq("full_strobe_single", wr_en, 0);
    chk_eq("full_count", byte_count, 'h1400);
    chk_eq("full_check_busy", busy, 1);
    wait_core_up(17, "full_hold_len");
    chk_eq("full_run_busy", busy, 0);
    chk_eq("full_err_size", err_size, 0);
    chk_eq("full_err_range", err_range, 0);
    $display("full load -> run, count 0x%0h", byte_count);

    soft_rst = 1'b1;
    tick();
    chk_eq("soft_core_low", core_rst_n, 0);
    chk_eq("soft_busy", busy, 1);
    repeat (4) tick();
    soft_rst = 1'b0;
    wait_core_up(16, "soft_hold_len");
    $display("soft reset in run released");

    dl_active = 1'b1;
    tick();
    chk_eq("short_core_low", core_rst_n, 0);
    chk_eq("short_count0", byte_count, 0);
    load_range(0, 'h13FE, 1'b0);
    end_download();
    tick();
    chk_eq("short_err_size", err_size, 1);
    chk_eq("short_err_range", err_range, 0);
    chk_eq("short_count", byte_count, 'h13FF);
    chk_eq("short_busy", busy, 0);
    soft_rst = 1'b1;
    repeat (3) tick();
    soft_rst = 1'b0;
    repeat (20) tick();
    chk_eq("short_soft_core", core_rst_n, 0);
    chk_eq("short_soft_busy", busy, 0);
    chk_eq("short_soft_err", err_size, 1);
    $display("short load -> error state held");

    dl_active = 1'b1;
    tick();
    chk_eq("oor_err_size_clr", err_size, 0);
    chk_eq("oor_count0", byte_count, 0);
    load_range(0, 'h1400, 1'b1);
    end_download();
    tick();
    chk_eq("oor_err_range", err_range, 1);
    chk_eq("oor_err_size", err_size, 0);
    chk_eq("oor_count", byte_count, 'h1400);
    chk_eq("oor_core", core_rst_n, 0);
    chk_eq("oor_busy", busy, 0);
    $display("out-of-range load -> error state");

    dl_active = 1'b1;
    tick();
    chk_eq("reload_err_range_clr", err_range, 0);
    load_range(0, 'h13FF, 1'b0);
    end_download();
    wait_core_up(17, "reload_hold_len");
    chk_eq("reload_count", byte_count, 'h1400);
    chk_eq("reload_errs", {err_size, err_range}, 0);
    $display("second full load -> run");

    dl_active = 1'b1;
    tick();
    chk_eq("run_reload_core", core_rst_n, 0);
    chk_eq("run_reload_count0", byte_count, 0);
    load_range(0, 'hFF, 1'b0);
    chk_eq("pre_arst_wr_en", wr_en, 4'b0001);
    chk_eq("pre_arst_count", byte_count, 'h100);
    #2 Reset_I = 1'b0;
    #1;
    check_reset_vals("arst");
    tick();
    Reset_I = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dl_addr = 25'(('h100) + i);
      tick();
      chk_eq("post_arst_wr_en", wr_en, 0);
      chk_eq("post_arst_count", byte_count, 0);
    end
    chk_eq("post_arst_busy", busy, 0);
    chk_eq("post_arst_core", core_rst_n, 0);
    dl_wr = 1'b0;
    $display("async reset mid-load returns to reset state");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
